// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// OVF exists only when SUB_SIGNED_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             ZERO;
    logic             BUSY;
`ifdef SUB_SIGNED_OVF_EN
    logic             OVF;
`endif

    modport master (
        output IN_VALID, A, B, Cin, OUT_READY,
        input  IN_READY, OUT_VALID, S, Cout, ZERO, BUSY
`ifdef SUB_SIGNED_OVF_EN
        , input OVF
`endif
    );

    modport slave (
        input  IN_VALID, A, B, Cin, OUT_READY,
        output IN_READY, OUT_VALID, S, Cout, ZERO, BUSY
`ifdef SUB_SIGNED_OVF_EN
        , output OVF
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Chunk-serial S = A - B - Cin, CHUNK bits per clock, LSB chunk first.
// Define SUB_SIGNED_OVF_EN to add the registered signed-overflow output OVF.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CLEAR,
    serial_subtractor_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_q, b_q, s_q, s_nxt;
    logic              borrow, cout_q, zero_q;
    logic [CW-1:0]     cnt;
    logic [CHUNK-1:0]  a_c, b_c;
    logic [CHUNK:0]    diff;
    logic              last, accept, in_ready;
`ifdef SUB_SIGNED_OVF_EN
    logic              ovf_q;
`endif

    assign accept = bus.IN_VALID && in_ready;
    assign last   = (cnt == CW'(NCHUNK - 1));

    // One CHUNK-bit slice; s_nxt is S with the current chunk merged in, so
    // ZERO/OVF can be formed on the final edge from the complete result.
    always_comb begin
        a_c   = a_q[cnt*CHUNK +: CHUNK];
        b_c   = b_q[cnt*CHUNK +: CHUNK];
        diff  = {1'b0, a_c} - {1'b0, b_c} - {{CHUNK{1'b0}}, borrow};
        s_nxt = s_q;
        s_nxt[cnt*CHUNK +: CHUNK] = diff[CHUNK-1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: if (bus.OUT_READY) state_nxt = bus.IN_VALID ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (CLEAR) state_nxt = IDLE;
    end

    always_comb begin
        in_ready      = 1'b0;
        bus.OUT_VALID = 1'b0;
        bus.BUSY      = 1'b0;
        unique case (state)
            IDLE:    in_ready      = 1'b1;
            RUN:     bus.BUSY      = 1'b1;
            DONE: begin
                bus.OUT_VALID = 1'b1;
                in_ready      = bus.OUT_READY;
            end
            default: ;
        endcase
        if (CLEAR) in_ready = 1'b0;
        bus.IN_READY = in_ready;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else if (accept) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            borrow <= bus.Cin;
            cnt    <= '0;
        end else if (state == RUN && !CLEAR) begin
            s_q    <= s_nxt;
            borrow <= diff[CHUNK];
            cnt    <= cnt + 1'b1;
            if (last) begin
                cout_q <= diff[CHUNK];
                zero_q <= (s_nxt == '0);
`ifdef SUB_SIGNED_OVF_EN
                ovf_q  <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_nxt[WIDTH-1] ^ diff[CHUNK];
`endif
            end
        end
    end

    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
    assign bus.ZERO = zero_q;
`ifdef SUB_SIGNED_OVF_EN
    assign bus.OVF  = ovf_q;
`endif
endmodule
